// File: rtl/bmp_frame_dumper_pkg.sv
// Shared definitions for the BMP frame dumper: FSM encoding, header layout and header byte generator.
// The trailer states exist only when DUMP_CHECKSUM_EN is defined.
package bmp_dump_pkg;

  localparam int unsigned BMP_HDR_BYTES   = 54;
  localparam int unsigned HDR_OFF_SIZE    = 2;
  localparam int unsigned HDR_OFF_OFFBITS = 10;
  localparam int unsigned HDR_OFF_BISIZE  = 14;
  localparam int unsigned HDR_OFF_WIDTH   = 18;
  localparam int unsigned HDR_OFF_HEIGHT  = 22;
  localparam int unsigned HDR_OFF_PLANES  = 26;
  localparam int unsigned HDR_OFF_BITCNT  = 28;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_HDR_W, S_RD, S_LAT, S_CONV, S_PIX, S_PIX_W, S_PAD, S_PAD_W,
`ifdef DUMP_CHECKSUM_EN
    S_TRL, S_TRL_W,
`endif
    S_DONE
  } state_e;

  // Little-endian header byte idx; all arguments are elaboration constants except idx.
  function automatic logic [7:0] bmp_hdr_byte(input int unsigned idx, input int unsigned w,
                                              input int unsigned h, input int unsigned bpp);
    logic [31:0] rowb, field, sh;
    int unsigned fbase;
    rowb  = ((w * bpp / 8) + 32'd3) & ~32'd3;
    field = 32'd0;
    fbase = idx;
    if (idx == 0)                                                field = 32'h42;
    else if (idx == 1)                                           field = 32'h4D;
    else if (idx >= HDR_OFF_SIZE    && idx < HDR_OFF_SIZE + 4)    begin field = BMP_HDR_BYTES + rowb * h; fbase = HDR_OFF_SIZE;    end
    else if (idx >= HDR_OFF_OFFBITS && idx < HDR_OFF_OFFBITS + 4) begin field = BMP_HDR_BYTES;            fbase = HDR_OFF_OFFBITS; end
    else if (idx >= HDR_OFF_BISIZE  && idx < HDR_OFF_BISIZE + 4)  begin field = 32'd40;                   fbase = HDR_OFF_BISIZE;  end
    else if (idx >= HDR_OFF_WIDTH   && idx < HDR_OFF_WIDTH + 4)   begin field = w;                        fbase = HDR_OFF_WIDTH;   end
    else if (idx >= HDR_OFF_HEIGHT  && idx < HDR_OFF_HEIGHT + 4)  begin field = h;                        fbase = HDR_OFF_HEIGHT;  end
    else if (idx >= HDR_OFF_PLANES  && idx < HDR_OFF_PLANES + 2)  begin field = 32'd1;                    fbase = HDR_OFF_PLANES;  end
    else if (idx >= HDR_OFF_BITCNT  && idx < HDR_OFF_BITCNT + 2)  begin field = bpp;                      fbase = HDR_OFF_BITCNT;  end
    sh = field >> (8 * (idx - fbase));
    return sh[7:0];
  endfunction

endpackage

// File: rtl/bmp_frame_dumper_if.sv
// SRAM read port plus byte-transmitter handshake seen by the BMP frame dumper.
interface bmp_frame_dumper_if #(parameter int ADDR_W = 18);
  logic              mem_oe_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rd;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic              tx_busy;

  modport master (output mem_oe_n, mem_addr, tx_start, tx_data, input  mem_rd, tx_busy);
  modport slave  (input  mem_oe_n, mem_addr, tx_start, tx_data, output mem_rd, tx_busy);
endinterface

// File: rtl/bmp_frame_dumper_pack.sv
// Latches one SRAM word (two RGB565 pixels) and selects output byte idx as BGR or BGR0.
module bmp_pixel_pack #(
  parameter int BPP = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic [31:0] word_i,
  input  logic [2:0]  idx_i,
  output logic [7:0]  byte_o
);

  logic [31:0] word_q;
  logic [15:0] px;
  logic        hi;
  logic [1:0]  comp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    word_q <= '0;
    else if (load_i) word_q <= word_i;
  end

  // Even pixel first; 3 bytes per pixel at 24 bpp, 4 at 32 bpp.
  always_comb begin
    hi   = 1'b0;
    comp = idx_i[1:0];
    if (BPP == 32) begin
      hi = idx_i[2];
    end else if (idx_i >= 3'd3) begin
      hi   = 1'b1;
      comp = 2'(idx_i - 3'd3);
    end
    px = hi ? word_q[31:16] : word_q[15:0];
    unique case (comp)
      2'd0:    byte_o = {px[4:0], 3'b000};
      2'd1:    byte_o = {px[10:5], 2'b00};
      2'd2:    byte_o = {px[15:11], 3'b000};
      default: byte_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/bmp_frame_dumper.sv
// Streams a captured RGB565 frame out of SRAM as a BMP file, rows bottom-up, one byte per tx handshake.
// DUMP_CHECKSUM_EN appends a 16-bit sum of pixel/pad bytes (low byte first) after the last row.
module bmp_frame_dumper
  import bmp_dump_pkg::*;
#(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int ADDR_W     = 18,
  parameter int BPP        = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dump_kick,
  input  logic              dump_abort,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              dump_busy,
  output logic              dump_done,
  output logic [ADDR_W-1:0] rest_words,
  bmp_frame_dumper_if.master bus
);

  localparam int WPR = IMG_W / 2;
  localparam int BPW = BPP / 4;
  localparam int PAD = (BPP == 24) ? ((-(IMG_W * 3)) & 3) : 0;
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CW  = (WPR > 1) ? $clog2(WPR) : 1;

  state_e            state_q, state_d;
  logic [2:0]        kick_q;
  logic              abort_q, abort_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [CW-1:0]     col_q, col_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        lat_q, lat_d;
  logic [ADDR_W-1:0] rest_q, rest_d;
  logic              oe_n_q, oe_n_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              start_q, start_d;
  logic [7:0]        data_q, data_d;
`ifdef DUMP_CHECKSUM_EN
  logic [15:0]       sum_q, sum_d;
`endif
  logic              kick_edge, abort_now, load, row_end;
  logic [7:0]        pix_byte;

  bmp_pixel_pack #(.BPP(BPP)) u_pack (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .word_i  (bus.mem_rd),
    .idx_i   (cnt_q[2:0]),
    .byte_o  (pix_byte)
  );

  assign kick_edge    = kick_q[1] & ~kick_q[2];
  assign abort_now    = abort_q | dump_abort;
  assign dump_busy    = (state_q != S_IDLE) && (state_q != S_DONE);
  assign dump_done    = (state_q == S_DONE);
  assign rest_words   = rest_q;
  assign bus.mem_oe_n = oe_n_q;
  assign bus.mem_addr = addr_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      kick_q     <= '0;
      abort_q    <= 1'b0;
      row_q      <= '0;
      row_base_q <= '0;
      col_q      <= '0;
      cnt_q      <= '0;
      lat_q      <= '0;
      rest_q     <= '0;
      oe_n_q     <= 1'b1;
      addr_q     <= '0;
      start_q    <= 1'b0;
      data_q     <= '0;
`ifdef DUMP_CHECKSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      kick_q     <= {kick_q[1:0], dump_kick};
      abort_q    <= abort_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      lat_q      <= lat_d;
      rest_q     <= rest_d;
      oe_n_q     <= oe_n_d;
      addr_q     <= addr_d;
      start_q    <= start_d;
      data_q     <= data_d;
`ifdef DUMP_CHECKSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    lat_d      = lat_q;
    rest_d     = rest_q;
    oe_n_d     = oe_n_q;
    addr_d     = addr_q;
    start_d    = 1'b0;
    data_d     = data_q;
    load       = 1'b0;
    row_end    = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    sum_d      = sum_q;
`endif
    if (dump_busy) abort_d = abort_now;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (kick_edge) begin
          state_d    = S_HDR;
          abort_d    = 1'b0;
          row_d      = RW'(IMG_H - 1);
          row_base_d = ADDR_W'((IMG_H - 1) * WPR);
          col_d      = '0;
          cnt_d      = '0;
          rest_d     = ADDR_W'(WPR * IMG_H);
`ifdef DUMP_CHECKSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_HDR: begin
        if (!bus.tx_busy) begin
          if (abort_now) state_d = S_DONE;
          else begin
            start_d = 1'b1;
            data_d  = bmp_hdr_byte(32'(cnt_q), IMG_W, IMG_H, BPP);
            state_d = S_HDR_W;
          end
        end
      end
      S_HDR_W: begin
        if (cnt_q == 8'(BMP_HDR_BYTES - 1)) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_HDR;
        end
      end
      S_RD: begin
        addr_d  = base_addr + row_base_q + ADDR_W'(col_q);
        oe_n_d  = 1'b0;
        rest_d  = rest_q - ADDR_W'(1);
        lat_d   = '0;
        state_d = S_LAT;
      end
      S_LAT: begin
        if (lat_q == 2'(MEM_RD_LAT - 1)) begin
          load    = 1'b1;
          oe_n_d  = 1'b1;
          state_d = S_CONV;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_CONV: begin
        cnt_d   = '0;
        state_d = S_PIX;
      end
      S_PIX: begin
        if (!bus.tx_busy) begin
          if (abort_now) state_d = S_DONE;
          else begin
            start_d = 1'b1;
            data_d  = pix_byte;
            state_d = S_PIX_W;
`ifdef DUMP_CHECKSUM_EN
            sum_d   = sum_q + {8'h00, pix_byte};
`endif
          end
        end
      end
      S_PIX_W: begin
        if (cnt_q == 8'(BPW - 1)) begin
          cnt_d = '0;
          if (col_q == CW'(WPR - 1)) begin
            col_d = '0;
            if (PAD != 0) state_d = S_PAD;
            else          row_end = 1'b1;
          end else begin
            col_d   = col_q + CW'(1);
            state_d = S_RD;
          end
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_PIX;
        end
      end
      S_PAD: begin
        if (!bus.tx_busy) begin
          if (abort_now) state_d = S_DONE;
          else begin
            start_d = 1'b1;
            data_d  = 8'h00;
            state_d = S_PAD_W;
          end
        end
      end
      S_PAD_W: begin
        if (cnt_q == 8'(PAD - 1)) begin
          cnt_d   = '0;
          row_end = 1'b1;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_PAD;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_TRL: begin
        if (!bus.tx_busy) begin
          if (abort_now) state_d = S_DONE;
          else begin
            start_d = 1'b1;
            data_d  = cnt_q[0] ? sum_q[15:8] : sum_q[7:0];
            state_d = S_TRL_W;
          end
        end
      end
      S_TRL_W: begin
        if (cnt_q[0]) state_d = S_DONE;
        else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_TRL;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Rows go out bottom-up, so the frame ends after row 0.
    if (row_end) begin
      if (row_q == '0) begin
`ifdef DUMP_CHECKSUM_EN
        state_d = S_TRL;
`else
        state_d = S_DONE;
`endif
      end else begin
        row_d      = row_q - RW'(1);
        row_base_d = row_base_q - ADDR_W'(WPR);
        state_d    = S_RD;
      end
    end
  end

endmodule

// File: tb/tb_bmp_frame_dumper.sv
// Directed bench: 2x2 frame dumped at 24 and 32 bpp side by side, with busy back-pressure, abort, wrap and reset.
module tb_bmp_frame_dumper;
  localparam int AW = 18;
`ifdef DUMP_CHECKSUM_EN
  localparam int NB = 72;
`else
  localparam int NB = 70;
`endif

  logic          clk = 1'b0, rst_n = 1'b1, kick = 1'b0, abort = 1'b0;
  logic [AW-1:0] base;
  logic          busy24, done24, busy32, done32;
  logic [AW-1:0] rest24, rest32;
  logic [AW-1:0] ma0, ma1;
  logic [31:0]   md0, md1;
  int            hold = 0;
  int            cnt24 = 0, cnt32 = 0, viol24 = 0, viol32 = 0;
  int            errs = 0, checks = 0;
  logic [7:0]    cap24[$], cap32[$];
  logic [AW-1:0] rd24[$];

  logic [7:0] hdr24 [54] = '{0:8'h42, 1:8'h4D, 2:8'h46, 10:8'h36, 14:8'h28, 18:8'h02,
                             22:8'h02, 26:8'h01, 28:8'h18, default:8'h00};
  logic [7:0] hdr32 [54] = '{0:8'h42, 1:8'h4D, 2:8'h46, 10:8'h36, 14:8'h28, 18:8'h02,
                             22:8'h02, 26:8'h01, 28:8'h20, default:8'h00};
  logic [7:0] pix24 [16] = '{8'hF8, 8'hFC, 8'hF8, 8'hF8, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00, 8'h00};
  logic [7:0] pix32 [16] = '{8'hF8, 8'hFC, 8'hF8, 8'h00, 8'hF8, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'hF8, 8'h00};

  bmp_frame_dumper_if #(.ADDR_W(AW)) b24 ();
  bmp_frame_dumper_if #(.ADDR_W(AW)) b32 ();

  bmp_frame_dumper #(.IMG_W(2), .IMG_H(2), .ADDR_W(AW), .BPP(24), .MEM_RD_LAT(1)) u24 (
    .clk(clk), .reset_n(rst_n), .dump_kick(kick), .dump_abort(abort), .base_addr(base),
    .dump_busy(busy24), .dump_done(done24), .rest_words(rest24), .bus(b24.master));

  bmp_frame_dumper #(.IMG_W(2), .IMG_H(2), .ADDR_W(AW), .BPP(32), .MEM_RD_LAT(1)) u32 (
    .clk(clk), .reset_n(rst_n), .dump_kick(kick), .dump_abort(abort), .base_addr(base),
    .dump_busy(busy32), .dump_done(done32), .rest_words(rest32), .bus(b32.master));

  always #5 clk = ~clk;

  // Single-cycle SRAM model: data valid while oe_n is low, poison otherwise.
  assign b24.mem_rd = b24.mem_oe_n ? 32'hDEAD_BEEF : (b24.mem_addr == ma0) ? md0 :
                      (b24.mem_addr == ma1) ? md1 : 32'hDEAD_BEEF;
  assign b32.mem_rd = b32.mem_oe_n ? 32'hDEAD_BEEF : (b32.mem_addr == ma0) ? md0 :
                      (b32.mem_addr == ma1) ? md1 : 32'hDEAD_BEEF;
  assign b24.tx_busy = (cnt24 != 0);
  assign b32.tx_busy = (cnt32 != 0);

  always @(posedge clk) begin
    if (b24.tx_start) begin
      if (b24.tx_busy) viol24 <= viol24 + 1;
      cap24.push_back(b24.tx_data);
      cnt24 <= hold;
    end else if (cnt24 != 0) cnt24 <= cnt24 - 1;
    if (!b24.mem_oe_n) rd24.push_back(b24.mem_addr);
  end

  always @(posedge clk) begin
    if (b32.tx_start) begin
      if (b32.tx_busy) viol32 <= viol32 + 1;
      cap32.push_back(b32.tx_data);
      cnt32 <= hold;
    end else if (cnt32 != 0) cnt32 <= cnt32 - 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int bpp, input int i);
    if (i < 54) return (bpp == 24) ? hdr24[i] : hdr32[i];
    if (i < 70) return (bpp == 24) ? pix24[i-54] : pix32[i-54];
    return (i == 70) ? 8'hD8 : 8'h05;
  endfunction

  task automatic check_stream(input string tag, input int bpp, input int s, input int nexp);
    int got_n;
    got_n = (bpp == 24) ? cap24.size() - s : cap32.size() - s;
    chk({tag, "_len"}, 64'(got_n), 64'(nexp));
    for (int i = 0; i < nexp && i < got_n; i++)
      chk($sformatf("%s_b%0d", tag, i), 64'((bpp == 24) ? cap24[s+i] : cap32[s+i]),
          64'(exp_byte(bpp, i)));
  endtask

  task automatic kick_pulse();
    @(negedge clk);
    kick = 1'b1;
    repeat (4) @(negedge clk);
    kick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!(done24 && done32) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(n < 5000), 64'd1);
  endtask

  initial begin
    int s24, s32, r, n;
    base = 18'h100;
    ma0 = 18'h100; md0 = 32'hF800_07E0;
    ma1 = 18'h101; md1 = 32'h001F_FFFF;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out24", {busy24, done24, b24.mem_oe_n, b24.tx_start, b24.tx_data, b24.mem_addr, rest24},
        {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, {AW{1'b0}}, {AW{1'b0}}});
    chk("rst_out32", {busy32, done32, b32.mem_oe_n, b32.tx_start}, 4'b0010);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy24, 0);

    // Plain dump, transmitter never busy
    hold = 0; s24 = cap24.size(); s32 = cap32.size(); r = rd24.size();
    kick_pulse();
    chk("c1_busy", busy24, 1);
    chk("c1_rest_start", rest24, 2);
    wait_done("c1");
    check_stream("c1_24", 24, s24, NB);
    check_stream("c1_32", 32, s32, NB);
    chk("c1_done", done24, 1);
    chk("c1_rest_end", rest24, 0);
    chk("c1_nrd", rd24.size() - r, 2);
    chk("c1_rd0", rd24[r], 18'h101);
    chk("c1_rd1", rd24[r+1], 18'h100);

    // Second kick with back-pressure: done clears, stream repeats
    hold = 5; s24 = cap24.size(); s32 = cap32.size();
    kick_pulse();
    chk("c2_done_clr", done24, 0);
    wait_done("c2");
    check_stream("c2_24", 24, s24, NB);
    check_stream("c2_32", 32, s32, NB);
    chk("c2_viol24", viol24, 0);
    chk("c2_viol32", viol32, 0);

    // Frame wrapping past the top of SRAM
    hold = 0; base = 18'h3FFFF; ma0 = 18'h3FFFF; ma1 = 18'h00000;
    s24 = cap24.size(); s32 = cap32.size(); r = rd24.size();
    kick_pulse();
    wait_done("wrap");
    check_stream("wrap_24", 24, s24, NB);
    check_stream("wrap_32", 32, s32, NB);
    chk("wrap_rd0", rd24[r], 18'h00000);
    chk("wrap_rd1", rd24[r+1], 18'h3FFFF);

    // Abort after the third row-0 byte
    hold = 5; base = 18'h100; ma0 = 18'h100; ma1 = 18'h101;
    s24 = cap24.size();
    kick_pulse();
    n = 0;
    while (cap24.size() < s24 + 65 && n < 3000) begin @(negedge clk); n++; end
    chk("abort_reach", 64'(n < 3000), 64'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n = 0;
    while (b24.tx_busy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!done24 && n < 10) begin @(negedge clk); n++; end
    chk("abort_done_lat", 64'(n <= 2), 64'd1);
    wait_done("abort");
    repeat (20) @(negedge clk);
    check_stream("abort_24", 24, s24, 65);
    chk("abort_viol24", viol24, 0);

    // Reset while a byte pulse is on the wire
    s24 = cap24.size();
    kick_pulse();
    n = 0;
    while (!b24.tx_start && n < 3000) begin @(negedge clk); n++; end
    chk("mrst_reach", 64'(n < 3000), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_out24", {busy24, done24, b24.mem_oe_n, b24.tx_start, b24.tx_data, b24.mem_addr, rest24},
        {1'b0, 1'b0, 1'b1, 1'b0, 8'h00, {AW{1'b0}}, {AW{1'b0}}});
    chk("mrst_out32", {busy32, done32, b32.mem_oe_n, b32.tx_start}, 4'b0010);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Clean dump after the reset
    hold = 0; s24 = cap24.size();
    kick_pulse();
    wait_done("rec");
    check_stream("rec_24", 24, s24, NB);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
